// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory bus arbiter.
package memory_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam logic [MASK_W-1:0] MASK_NONE = 4'hf;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
        logic              we;
    } bus_req_t;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 2) return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
module memory_arbiter_pick
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned STARVE_W     = 3
) (
    input  logic                i_cpu_req,
    input  logic                i_dma_req,
    input  logic                i_last_grant,
    input  logic [STARVE_W-1:0] i_starve_cnt,
    output logic                o_grant_dma_c,
    output logic                o_grant_valid_c
);

    always_comb begin
        o_grant_valid_c = i_cpu_req | i_dma_req;
        o_grant_dma_c   = i_dma_req;
        // Only a tie needs a policy; a lone requester always wins.
        if (i_cpu_req && i_dma_req) begin
            if (CPU_PRIORITY == 0) begin
                o_grant_dma_c = (i_last_grant == OWNER_CPU);
            end else begin
                o_grant_dma_c = (i_starve_cnt == STARVE_W'(STARVE_LIMIT));
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory_bus port between CPU and DMA: grant, one-cycle issue,
// latency wait, data capture and a single-cycle ready pulse to the winner.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned BUS_LATENCY  = 1,
    parameter int unsigned CPU_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_write_enable,
    input  logic [DATA_W-1:0] cpu_write_data,
    input  logic [MASK_W-1:0] cpu_write_mask,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_read_data,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic              dma_write_enable,
    input  logic [DATA_W-1:0] dma_write_data,
    input  logic [MASK_W-1:0] dma_write_mask,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_read_data,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_data_in,
    output logic [MASK_W-1:0] bus_write_mask,
    output logic              bus_enable,
    output logic              bus_write_enable,
    input  logic [DATA_W-1:0] bus_data_out,
    output logic              owner
);

    localparam int unsigned WAIT_W   = cnt_width(BUS_LATENCY - 1);
    localparam int unsigned STARVE_W = cnt_width(STARVE_LIMIT);

    state_t              r_state,      w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt,   w_wait_cnt_nxt;
    logic [STARVE_W-1:0] r_starve_cnt, w_starve_cnt_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    bus_req_t            r_bus,        w_bus_nxt;
    logic                r_bus_en,     w_bus_en_nxt;
    logic                r_bus_we,     w_bus_we_nxt;
    logic                r_cpu_ready,  w_cpu_ready_nxt;
    logic                r_dma_ready,  w_dma_ready_nxt;
    logic [DATA_W-1:0]   r_cpu_rdata,  w_cpu_rdata_nxt;
    logic [DATA_W-1:0]   r_dma_rdata,  w_dma_rdata_nxt;
    logic                r_owner,      w_owner_nxt;

    bus_req_t w_cpu_fields;
    bus_req_t w_dma_fields;
    logic     w_grant_dma;
    logic     w_grant_valid;

    assign w_cpu_fields = '{addr: cpu_address, data: cpu_write_data,
                            mask: cpu_write_mask, we: cpu_write_enable};
    assign w_dma_fields = '{addr: dma_address, data: dma_write_data,
                            mask: dma_write_mask, we: dma_write_enable};

    memory_arbiter_pick #(
        .CPU_PRIORITY (CPU_PRIORITY),
        .STARVE_LIMIT (STARVE_LIMIT),
        .STARVE_W     (STARVE_W)
    ) u_pick (
        .i_cpu_req       (cpu_req),
        .i_dma_req       (dma_req),
        .i_last_grant    (r_last_grant),
        .i_starve_cnt    (r_starve_cnt),
        .o_grant_dma_c   (w_grant_dma),
        .o_grant_valid_c (w_grant_valid)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_starve_cnt_nxt = r_starve_cnt;
        w_last_grant_nxt = r_last_grant;
        w_bus_nxt        = r_bus;
        w_bus_en_nxt     = 1'b0;
        w_bus_we_nxt     = 1'b0;
        w_cpu_ready_nxt  = 1'b0;
        w_dma_ready_nxt  = 1'b0;
        w_cpu_rdata_nxt  = r_cpu_rdata;
        w_dma_rdata_nxt  = r_dma_rdata;
        w_owner_nxt      = r_owner;

        case (r_state)
            ST_IDLE: begin
                if (!dma_req) w_starve_cnt_nxt = '0;
                if (w_grant_valid) begin
                    w_owner_nxt      = w_grant_dma;
                    w_last_grant_nxt = w_grant_dma;
                    w_bus_nxt        = w_grant_dma ? w_dma_fields : w_cpu_fields;
                    w_bus_en_nxt     = 1'b1;
                    w_bus_we_nxt     = w_grant_dma ? dma_write_enable : cpu_write_enable;
                    w_state_nxt      = ST_ISSUE;
                    if (w_grant_dma) begin
                        w_starve_cnt_nxt = '0;
                    end else if (dma_req && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
                        w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                w_wait_cnt_nxt = WAIT_W'(BUS_LATENCY - 1);
                w_state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    if (r_owner == OWNER_DMA) begin
                        w_dma_rdata_nxt = bus_data_out;
                        w_dma_ready_nxt = 1'b1;
                    end else begin
                        w_cpu_rdata_nxt = bus_data_out;
                        w_cpu_ready_nxt = 1'b1;
                    end
                    w_state_nxt = ST_DONE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_last_grant <= OWNER_DMA;
            r_bus        <= '{addr: '0, data: '0, mask: MASK_NONE, we: 1'b0};
            r_bus_en     <= 1'b0;
            r_bus_we     <= 1'b0;
            r_cpu_ready  <= 1'b0;
            r_dma_ready  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_owner      <= OWNER_CPU;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_bus        <= w_bus_nxt;
            r_bus_en     <= w_bus_en_nxt;
            r_bus_we     <= w_bus_we_nxt;
            r_cpu_ready  <= w_cpu_ready_nxt;
            r_dma_ready  <= w_dma_ready_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_dma_rdata  <= w_dma_rdata_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    assign bus_address      = r_bus.addr;
    assign bus_data_in      = r_bus.data;
    assign bus_write_mask   = r_bus.mask;
    assign bus_enable       = r_bus_en;
    assign bus_write_enable = r_bus_we;
    assign cpu_ready        = r_cpu_ready;
    assign dma_ready        = r_dma_ready;
    assign cpu_read_data    = r_cpu_rdata;
    assign dma_read_data    = r_dma_rdata;
    assign owner            = r_owner;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two configurations (fixed priority / latency 1 and
// round-robin / latency 3) driven by the same requesters, each with its own bus memory.
module tb_memory_arbiter;

    localparam int STARVE = 4;
    localparam int LAT  [2] = '{1, 3};
    localparam int PRIO [2] = '{1, 0};

    logic        clk;
    logic        reset;
    logic        cpu_req, dma_req;
    logic [15:0] cpu_address, dma_address;
    logic        cpu_we, dma_we;
    logic [31:0] cpu_wdata, dma_wdata;
    logic [3:0]  cpu_mask, dma_mask;

    logic        cpu_ready [2];
    logic        dma_ready [2];
    logic [31:0] cpu_rd    [2];
    logic [31:0] dma_rd    [2];
    logic [15:0] bus_addr  [2];
    logic [31:0] bus_din   [2];
    logic [3:0]  bus_mask  [2];
    logic        bus_en    [2];
    logic        bus_we    [2];
    logic [31:0] bus_dout  [2];
    logic        owner     [2];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Environment: word memories and read-latency pipelines, one per instance.
    logic [31:0] env_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] pipe [2][3];

    // Reference model: transaction timeline per instance.
    bit          m_busy [2];
    int          m_t    [2];
    bit          m_win  [2];
    bit          m_last [2];
    int          m_starve [2];
    logic [15:0] e_addr [2];
    logic [31:0] e_din  [2];
    logic [3:0]  e_mask [2];
    bit          e_we   [2];
    bit          e_owner[2];
    logic [31:0] e_cap  [2];
    logic [31:0] e_cpu_rd [2];
    logic [31:0] e_dma_rd [2];

    bit ord_a[$];
    bit ord_b[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter #(.BUS_LATENCY(1), .CPU_PRIORITY(1), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_write_enable(cpu_we),
        .cpu_write_data(cpu_wdata), .cpu_write_mask(cpu_mask),
        .cpu_ready(cpu_ready[0]), .cpu_read_data(cpu_rd[0]),
        .dma_req(dma_req), .dma_address(dma_address), .dma_write_enable(dma_we),
        .dma_write_data(dma_wdata), .dma_write_mask(dma_mask),
        .dma_ready(dma_ready[0]), .dma_read_data(dma_rd[0]),
        .bus_address(bus_addr[0]), .bus_data_in(bus_din[0]), .bus_write_mask(bus_mask[0]),
        .bus_enable(bus_en[0]), .bus_write_enable(bus_we[0]), .bus_data_out(bus_dout[0]),
        .owner(owner[0])
    );

    memory_arbiter #(.BUS_LATENCY(3), .CPU_PRIORITY(0), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_write_enable(cpu_we),
        .cpu_write_data(cpu_wdata), .cpu_write_mask(cpu_mask),
        .cpu_ready(cpu_ready[1]), .cpu_read_data(cpu_rd[1]),
        .dma_req(dma_req), .dma_address(dma_address), .dma_write_enable(dma_we),
        .dma_write_data(dma_wdata), .dma_write_mask(dma_mask),
        .dma_ready(dma_ready[1]), .dma_read_data(dma_rd[1]),
        .bus_address(bus_addr[1]), .bus_data_in(bus_din[1]), .bus_write_mask(bus_mask[1]),
        .bus_enable(bus_en[1]), .bus_write_enable(bus_we[1]), .bus_data_out(bus_dout[1]),
        .owner(owner[1])
    );

    function automatic int unsigned mkey(input int k, input logic [15:0] a);
        return 32'(k) * 32'd65536 + 32'(a >> 2);
    endfunction

    function automatic logic [31:0] init_word(input int unsigned key);
        return (key * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (!mask[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Applies the arbitration rules at one clock edge, given pre-edge inputs.
    task automatic model_edge(input int k, input bit rst, input bit creq, input bit dreq,
                              input logic [15:0] ca, input bit cw, input logic [31:0] cd,
                              input logic [3:0] cm, input logic [15:0] da, input bit dw,
                              input logic [31:0] dd, input logic [3:0] dm);
        int unsigned key;
        logic [31:0] old;
        if (rst) begin
            m_busy[k] = 0; m_t[k] = 0; m_last[k] = 1; m_starve[k] = 0;
            e_addr[k] = '0; e_din[k] = '0; e_mask[k] = 4'hf; e_we[k] = 0;
            e_owner[k] = 0; e_cpu_rd[k] = '0; e_dma_rd[k] = '0;
        end else if (!m_busy[k]) begin
            if (!dreq) m_starve[k] = 0;
            if (creq || dreq) begin
                if (creq && dreq)
                    m_win[k] = (PRIO[k] == 0) ? (m_last[k] == 0) : (m_starve[k] == STARVE);
                else
                    m_win[k] = dreq;
                if (m_win[k]) m_starve[k] = 0;
                else if (dreq && m_starve[k] < STARVE) m_starve[k]++;
                m_last[k]  = m_win[k];
                e_owner[k] = m_win[k];
                e_addr[k]  = m_win[k] ? da : ca;
                e_din[k]   = m_win[k] ? dd : cd;
                e_mask[k]  = m_win[k] ? dm : cm;
                e_we[k]    = m_win[k] ? dw : cw;
                key = mkey(k, e_addr[k]);
                old = ref_mem.exists(key) ? ref_mem[key] : init_word(key);
                e_cap[k] = e_we[k] ? merge(old, e_din[k], e_mask[k]) : old;
                if (e_we[k]) ref_mem[key] = e_cap[k];
                m_busy[k] = 1;
                m_t[k]    = 1;
            end
        end else if (m_t[k] == 2 + LAT[k]) begin
            m_busy[k] = 0;
        end else begin
            m_t[k]++;
            if (m_t[k] == 2 + LAT[k]) begin
                if (m_win[k]) e_dma_rd[k] = e_cap[k];
                else          e_cpu_rd[k] = e_cap[k];
            end
        end
    endtask

    task automatic compare_all(input int k);
        bit phase_issue, phase_done;
        string s;
        phase_issue = m_busy[k] && (m_t[k] == 1);
        phase_done  = m_busy[k] && (m_t[k] == 2 + LAT[k]);
        s = (k == 0) ? "a" : "b";
        chk({"bus_enable_", s},       32'(bus_en[k]),    32'(phase_issue));
        chk({"bus_write_enable_", s}, 32'(bus_we[k]),    32'(phase_issue && e_we[k]));
        chk({"bus_address_", s},      32'(bus_addr[k]),  32'(e_addr[k]));
        chk({"bus_data_in_", s},      bus_din[k],        e_din[k]);
        chk({"bus_write_mask_", s},   32'(bus_mask[k]),  32'(e_mask[k]));
        chk({"owner_", s},            32'(owner[k]),     32'(e_owner[k]));
        chk({"cpu_ready_", s},        32'(cpu_ready[k]), 32'(phase_done && !m_win[k]));
        chk({"dma_ready_", s},        32'(dma_ready[k]), 32'(phase_done && m_win[k]));
        chk({"cpu_read_data_", s},    cpu_rd[k],         e_cpu_rd[k]);
        chk({"dma_read_data_", s},    dma_rd[k],         e_dma_rd[k]);
    endtask

    // One clock: bus environment, reference model, then full output comparison.
    task automatic step();
        bit s_rst, s_creq, s_dreq, s_cw, s_dw;
        logic [15:0] s_ca, s_da;
        logic [31:0] s_cd, s_dd;
        logic [3:0]  s_cm, s_dm;
        logic        s_en [2];
        logic        s_we [2];
        logic [15:0] s_addr [2];
        logic [31:0] s_din [2];
        logic [3:0]  s_mask [2];
        int unsigned key;
        logic [31:0] old, nw;
        s_rst = reset; s_creq = cpu_req; s_dreq = dma_req;
        s_ca = cpu_address; s_cw = cpu_we; s_cd = cpu_wdata; s_cm = cpu_mask;
        s_da = dma_address; s_dw = dma_we; s_dd = dma_wdata; s_dm = dma_mask;
        for (int k = 0; k < 2; k++) begin
            s_en[k] = bus_en[k]; s_we[k] = bus_we[k]; s_addr[k] = bus_addr[k];
            s_din[k] = bus_din[k]; s_mask[k] = bus_mask[k];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            for (int s = 2; s > 0; s--) pipe[k][s] = pipe[k][s-1];
            if (s_en[k] === 1'b1) begin
                key = mkey(k, s_addr[k]);
                old = env_mem.exists(key) ? env_mem[key] : init_word(key);
                nw  = (s_we[k] === 1'b1) ? merge(old, s_din[k], s_mask[k]) : old;
                if (s_we[k] === 1'b1) env_mem[key] = nw;
                pipe[k][0] = nw;
            end else begin
                pipe[k][0] = 32'hBAD0_0000 ^ 32'(cyc);
            end
            bus_dout[k] = pipe[k][LAT[k]-1];
            model_edge(k, s_rst, s_creq, s_dreq, s_ca, s_cw, s_cd, s_cm, s_da, s_dw, s_dd, s_dm);
            compare_all(k);
        end
        if (cpu_ready[0]) ord_a.push_back(1'b0);
        if (dma_ready[0]) ord_a.push_back(1'b1);
        if (cpu_ready[1]) ord_b.push_back(1'b0);
        if (dma_ready[1]) ord_b.push_back(1'b1);
    endtask

    initial begin
        bit exp_a [6];
        bit exp_b [4];
        exp_a = '{0, 0, 0, 0, 1, 0};
        exp_b = '{0, 1, 0, 1};

        reset = 1'b1;
        cpu_req = 0; cpu_address = '0; cpu_we = 0; cpu_wdata = '0; cpu_mask = 4'hf;
        dma_req = 0; dma_address = '0; dma_we = 0; dma_wdata = '0; dma_mask = 4'hf;
        for (int k = 0; k < 2; k++) begin
            bus_dout[k] = '0;
            for (int s = 0; s < 3; s++) pipe[k][s] = '0;
            env_mem[mkey(k, 16'h4000)] = 32'hDEADBEEF;
            ref_mem[mkey(k, 16'h4000)] = 32'hDEADBEEF;
        end

        // Reset values
        step(); step();
        chk("reset_bus_mask", 32'(bus_mask[0]), 32'h0000000f);
        chk("reset_bus_enable", 32'(bus_en[1]), 32'd0);
        chk("reset_owner", 32'(owner[0]), 32'd0);
        reset = 1'b0;

        // CPU load of 0x4000, request dropped one cycle after grant
        cpu_req = 1; cpu_address = 16'h4000; cpu_we = 0;
        step();
        chk("load_enable_c1", 32'(bus_en[0]), 32'd1);
        chk("load_address_c1", 32'(bus_addr[0]), 32'h4000);
        cpu_req = 0;
        step();
        chk("load_enable_c2", 32'(bus_en[0]), 32'd0);
        step();
        chk("load_ready_c3", 32'(cpu_ready[0]), 32'd1);
        chk("load_data_c3", cpu_rd[0], 32'hDEADBEEF);
        step();
        chk("lat3_not_ready_c4", 32'(cpu_ready[1]), 32'd0);
        step();
        chk("lat3_ready_c5", 32'(cpu_ready[1]), 32'd1);
        chk("lat3_data_c5", cpu_rd[1], 32'hDEADBEEF);
        step();

        // DMA full-word store to 0x8004, then readback
        dma_req = 1; dma_address = 16'h8004; dma_we = 1; dma_wdata = 32'h11223344; dma_mask = 4'b0000;
        step();
        chk("store_we_issue", 32'(bus_we[0]), 32'd1);
        dma_req = 0;
        step();
        chk("store_we_wait", 32'(bus_we[0]), 32'd0);
        step();
        chk("store_ready", 32'(dma_ready[0]), 32'd1);
        step();
        chk("store_ready_one_cycle", 32'(dma_ready[0]), 32'd0);
        repeat (4) step();
        dma_req = 1; dma_we = 0; dma_mask = 4'hf;
        step();
        dma_req = 0;
        repeat (2) step();
        chk("readback_a", dma_rd[0], 32'h11223344);
        repeat (2) step();
        chk("readback_b", dma_rd[1], 32'h11223344);
        repeat (2) step();

        // Both requesters held: starvation guard vs round-robin
        reset = 1; step(); reset = 0;
        ord_a.delete(); ord_b.delete();
        cpu_req = 1; cpu_address = 16'h8000; cpu_we = 0;
        dma_req = 1; dma_address = 16'h8004; dma_we = 0;
        repeat (40) step();
        cpu_req = 0; dma_req = 0;
        repeat (8) step();
        for (int i = 0; i < 6; i++)
            chk($sformatf("order_prio_%0d", i),
                (ord_a.size() > i) ? 32'(ord_a[i]) : 32'hFFFFFFFF, 32'(exp_a[i]));
        for (int i = 0; i < 4; i++)
            chk($sformatf("order_rr_%0d", i),
                (ord_b.size() > i) ? 32'(ord_b[i]) : 32'hFFFFFFFF, 32'(exp_b[i]));

        // Reset during WAIT of a DMA access with a CPU request pending
        ord_a.delete(); ord_b.delete();
        dma_req = 1; dma_address = 16'h8008;
        step();
        cpu_req = 1; cpu_address = 16'h4000; cpu_we = 0;
        step();
        reset = 1; dma_req = 0;
        step();
        chk("midreset_dma_ready", 32'(dma_ready[0]), 32'd0);
        chk("midreset_enable", 32'(bus_en[0]), 32'd0);
        chk("midreset_dma_rd", dma_rd[0], 32'd0);
        reset = 0;
        step();
        chk("after_reset_owner_a", 32'(owner[0]), 32'd0);
        chk("after_reset_enable_b", 32'(bus_en[1]), 32'd1);
        cpu_req = 0;
        repeat (6) step();
        chk("after_reset_count_a", 32'(ord_a.size()), 32'd1);
        chk("after_reset_cpu_rd_a", cpu_rd[0], 32'hDEADBEEF);

        // DMA request pulsed only during the ISSUE cycle of a CPU access
        ord_a.delete(); ord_b.delete();
        cpu_req = 1; cpu_address = 16'h8000;
        step();
        cpu_req = 0; dma_req = 1;
        step();
        dma_req = 0;
        repeat (8) step();
        chk("pulse_count_a", 32'(ord_a.size()), 32'd1);
        chk("pulse_count_b", 32'(ord_b.size()), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) cpu_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 4) == 0) dma_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                cpu_address = 16'(32'h8000 + 4 * $urandom_range(0, 7));
                cpu_we = 1'($urandom_range(0, 1));
                cpu_wdata = $urandom; cpu_mask = 4'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                dma_address = 16'(32'h8000 + 4 * $urandom_range(0, 7));
                dma_we = 1'($urandom_range(0, 1));
                dma_wdata = $urandom; dma_mask = 4'($urandom);
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
